// File: rtl/opsum_push_mask_gen.sv
// Per-channel push-enable mask for the opsum FIFO bank: pointwise ramp-up,
// depthwise fixed lanes, standard all-open, and a ramp-down drain phase.
module opsum_push_mask_gen #(
  parameter int NUM_CH   = 32,
  parameter int DW_LANES = 10,
  parameter int CNT_W    = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        layer_type_i,
  input  logic [CNT_W-1:0]  oc_real_i,
  input  logic              start_i,
  input  logic              normal_loop_i,
  input  logic              push_one_i,
  input  logic [NUM_CH-1:0] ifmap_pop_i,
  input  logic              drain_i,
  output logic [NUM_CH-1:0] opsum_fifo_mask_o,
  output logic [CNT_W-1:0]  active_cnt_o,
  output logic              ramp_full_o,
  output logic              drain_done_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, RAMP, FULL, DRAIN} state_t;

  localparam logic [1:0] LT_PW  = 2'd0;
  localparam logic [1:0] LT_DW  = 2'd1;
  localparam logic [1:0] LT_STD = 2'd2;
  localparam int         DW_EFF = (DW_LANES < NUM_CH) ? DW_LANES : NUM_CH;

  // Channel counts above NUM_CH saturate to the physical FIFO count.
  function automatic logic [CNT_W-1:0] sat_oc(input logic [CNT_W-1:0] oc);
    if (oc > CNT_W'(NUM_CH)) return CNT_W'(NUM_CH);
    return oc;
  endfunction

  // Low-n-bits mask, built one bit wider so n == NUM_CH gives all ones.
  function automatic logic [NUM_CH-1:0] lane_mask(input logic [CNT_W-1:0] n);
    logic [NUM_CH:0] wide;
    wide = ((NUM_CH + 1)'(1) << n) - (NUM_CH + 1)'(1);
    return wide[NUM_CH-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_CH-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction

  state_t            state, state_n;
  logic [NUM_CH-1:0] dyn_mask, dyn_n;
  logic [1:0]        mode_q, mode_n;
  logic [CNT_W-1:0]  oc_q, oc_n;
  logic              done_q, done_n;

  logic              step;
  logic [NUM_CH-1:0] static_mask;
  logic [NUM_CH-1:0] fill_shift;
  logic [NUM_CH-1:0] drain_shift;
  logic [CNT_W-1:0]  oc_in_eff;

  assign step        = normal_loop_i & (|ifmap_pop_i);
  assign static_mask = lane_mask(sat_oc(oc_q));
  assign fill_shift  = (dyn_mask << 1) | NUM_CH'(1);
  assign drain_shift = dyn_mask << 1;
  assign oc_in_eff   = sat_oc(oc_real_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dyn_mask <= '0;
      mode_q   <= '0;
      oc_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      dyn_mask <= dyn_n;
      mode_q   <= mode_n;
      oc_q     <= oc_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    dyn_n   = dyn_mask;
    mode_n  = mode_q;
    oc_n    = oc_q;
    done_n  = 1'b0;
    if (start_i) begin
      mode_n = layer_type_i;
      oc_n   = oc_real_i;
      if (oc_real_i == '0) begin
        state_n = IDLE;
        dyn_n   = '0;
      end else begin
        case (layer_type_i)
          LT_PW: begin
            dyn_n   = NUM_CH'(1);
            state_n = (oc_in_eff == CNT_W'(1)) ? FULL : RAMP;
          end
          LT_DW: begin
            dyn_n   = lane_mask(CNT_W'(DW_EFF));
            state_n = FULL;
          end
          LT_STD: begin
            dyn_n   = '1;
            state_n = FULL;
          end
          default: begin
            dyn_n   = '0;
            state_n = IDLE;
          end
        endcase
      end
    end else begin
      case (state)
        RAMP: begin
          if (drain_i) begin
            state_n = DRAIN;
          end else if (step) begin
            dyn_n = fill_shift;
            if ((fill_shift & static_mask) == static_mask) state_n = FULL;
          end
        end
        FULL: begin
          if (drain_i) state_n = DRAIN;
        end
        DRAIN: begin
          if (step) begin
            dyn_n = drain_shift;
            // Lower lanes close first; the tile is done once no real lane is open.
            if ((drain_shift & static_mask) == '0) begin
              state_n = IDLE;
              dyn_n   = '0;
              done_n  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    opsum_fifo_mask_o = '0;
    if ((state != IDLE) && (normal_loop_i || push_one_i))
      opsum_fifo_mask_o = dyn_mask & static_mask;
  end

  assign active_cnt_o = popcnt(opsum_fifo_mask_o);
  assign ramp_full_o  = (state == FULL);
  assign drain_done_o = done_q;
  assign busy_o       = (state != IDLE);

endmodule

// File: doc/opsum_push_mask_gen.md
Name: opsum_push_mask_gen

Overview:
- Generates the per-channel push-enable mask for the opsum FIFO bank in the token engine.
- Generalises the fixed 32-channel mask to NUM_CH channels, with three layer modes: pointwise ramp-up, depthwise fixed lanes and standard all-open.
- Adds a drain (ramp-down) phase, so lower FIFOs close first after the last ifmap column, plus status outputs for the tile controller.
- Sits between the token-engine FSM and the opsum FIFO push logic.

Parameters:
- NUM_CH, 32, number of opsum FIFOs / mask bits.
- DW_LANES, 10, lanes opened in depthwise mode (clamped to NUM_CH).
- CNT_W, $clog2(NUM_CH+1), width of channel counts.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- layer_type_i  in  2  0 = POINTWISE, 1 = DEPTHWISE, 2 = STANDARD, 3 = reserved
- oc_real_i  in  CNT_W  real output channels for the tile
- start_i  in  1  tile start pulse; latches mode and oc_real, initialises mask
- normal_loop_i  in  1  token engine in normal loop state
- push_one_i  in  1  single post-preheat push window
- ifmap_pop_i  in  NUM_CH  ifmap FIFO pop matrix; OR-reduced to one step event
- drain_i  in  1  last ifmap consumed; begin ramp-down
- opsum_fifo_mask_o  out  NUM_CH  push-enable mask
- active_cnt_o  out  CNT_W  popcount of opsum_fifo_mask_o
- ramp_full_o  out  1  high while state == FULL
- drain_done_o  out  1  one-cycle pulse when the drain empties the mask
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE; dyn_mask, mode_q and oc_q cleared to 0. All outputs 0.
- step = normal_loop_i & |ifmap_pop_i.
- oc_eff = min(oc_q, NUM_CH). static_mask = (1<<oc_eff) - 1, or 0 when oc_eff == 0. Compute in NUM_CH+1 bits so oc_eff == NUM_CH yields all ones.
- opsum_fifo_mask_o = dyn_mask & static_mask when state != IDLE and (normal_loop_i | push_one_i); otherwise 0. This path is combinational, zero latency from the gating inputs.
- States: IDLE, RAMP, FULL, DRAIN.
- start_i has top priority in every state, so a mid-operation start restarts cleanly.
  - Latch mode_q and oc_q from the inputs.
  - oc_real_i == 0: go to IDLE, dyn = 0.
  - POINTWISE: dyn = 1. Go to FULL if oc_eff == 1, else RAMP.
  - DEPTHWISE: dyn = (1 << min(DW_LANES, NUM_CH)) - 1; go to FULL.
  - STANDARD: dyn = all ones; go to FULL.
  - Reserved mode: go to IDLE, dyn = 0.
- RAMP:
  - drain_i: go to DRAIN, dyn unchanged; a step in the same cycle is ignored.
  - Else on step: dyn = (dyn << 1) | 1. If (new dyn & static_mask) == static_mask, go to FULL.
- FULL:
  - drain_i: go to DRAIN. A step in the same cycle is ignored.
  - Steps otherwise do not change dyn.
- DRAIN:
  - On step: dyn = dyn << 1 (no fill). If (new dyn & static_mask) == 0, go to IDLE, clear dyn, and pulse drain_done_o for one cycle.
  - Bits shifted past bit NUM_CH-1 are discarded.
- drain_i while IDLE is ignored.
- No step is consumed while normal_loop_i is low, even if ifmap_pop_i is nonzero.
- A mode_q or oc_q change only takes effect on start_i. Input changes mid-tile do not alter the mask.
- active_cnt_o is the combinational popcount of the gated output mask.

Test Plan:
- POINTWISE, NUM_CH=32, oc=4. Start, then normal_loop_i=1, then 3 steps. Required: mask 0x1→0x3→0x7→0xF; ramp_full_o rises on the 3rd step; the 4th step leaves 0xF.
- Continuing from FULL with mask 0xF: drain_i, then 4 steps. Required: mask 0xE→0xC→0x8; the 4th step gives 0x0 and drain_done_o pulses once; busy_o falls.
- DEPTHWISE, oc=6, DW_LANES=10. Start, then normal_loop_i=1. Required: mask 0x3F, active_cnt 6. With oc=32 instead: mask 0x3FF, active_cnt 10.
- STANDARD, oc=40 (clamped to 32). Required: mask 0xFFFFFFFF, active_cnt 32. With normal_loop_i=0 and push_one_i=1: mask unchanged. With both low: mask 0.
- POINTWISE, oc=8, mask at 0x7. Step with normal_loop_i=0: mask stays 0x7. Then start_i together with a step: restarts to 0x1. Apply rst_n low mid-DRAIN: all outputs 0 immediately.
- oc_real_i=0 or layer_type_i=3 with start_i: stays IDLE, mask 0, busy_o 0, no drain_done_o.
